// File: rtl/fams_key_pkg.sv
// Shared types and board timing defaults for the push-button front end.
package fams_key_pkg;

    typedef enum logic [1:0] {
        REL        = 2'd0,
        PRESS_WAIT = 2'd1,
        PRS        = 2'd2,
        REL_WAIT   = 2'd3
    } key_state_e;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 20;
    localparam int LONG_MS     = 1000;

    // Cycle counts derived from the board clock: 1_000_000 and 50_000_000.
    localparam int DEBOUNCE_CYC_DEF = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC_DEF     = CLK_HZ / 1000 * LONG_MS;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM, long-press counter and registered strobes.
module key_debounce_ch
    import fams_key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC     = LONG_CYC_DEF
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYC);
    localparam int LCNT_W = $clog2(LONG_CYC + 1);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LONG_CYC);
    localparam logic [LCNT_W-1:0] LCNT_PRE = LCNT_W'(LONG_CYC - 1);

    logic              sync1_q, sync2_q;
    key_state_e        state_q, state_d, prev_q;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              lhit_q, lhit_d;
    logic              level_q, press_q, release_q, long_q;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            REL: begin
                if (!sync2_q) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = DCNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (sync2_q) begin
                    state_d = REL;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_MAX) begin
                    state_d = PRS;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            PRS: begin
                if (sync2_q) begin
                    state_d = REL_WAIT;
                    dcnt_d  = DCNT_W'(1);
                end
            end
            REL_WAIT: begin
                if (!sync2_q) begin
                    state_d = PRS;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_MAX) begin
                    state_d = REL;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: begin
                state_d = REL;
                dcnt_d  = '0;
            end
        endcase
    end

    // Counting stops on the cycle that commits a release so key_long never lands on key_release.
    always_comb begin
        lcnt_d = lcnt_q;
        lhit_d = 1'b0;
        if (state_q == PRESS_WAIT && state_d == PRS) begin
            lcnt_d = '0;
        end else if ((state_q == PRS || state_q == REL_WAIT) && state_d != REL
                     && lcnt_q != LCNT_MAX) begin
            lcnt_d = lcnt_q + LCNT_W'(1);
            lhit_d = (lcnt_q == LCNT_PRE);
        end
    end

    // NOTE: every flop here, synchroniser included, is cleared by the async reset; sync FFs load 1
    // (released) so a key held through reset is seen as a fresh press.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= REL;
            prev_q    <= REL;
            dcnt_q    <= '0;
            lcnt_q    <= '0;
            lhit_q    <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= key_n_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            prev_q    <= state_q;
            dcnt_q    <= dcnt_d;
            lcnt_q    <= lcnt_d;
            lhit_q    <= lhit_d;
            level_q   <= (state_q == PRS) || (state_q == REL_WAIT);
            press_q   <= (state_q == PRS) && (prev_q == PRESS_WAIT);
            release_q <= (state_q == REL) && (prev_q == REL_WAIT);
            long_q    <= lhit_q;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/key_debounce.sv
// Board push-button front end: NUM_KEYS independent debounce channels.
module key_debounce
    import fams_key_pkg::*;
#(
    parameter int NUM_KEYS     = 2,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC     = LONG_CYC_DEF
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    if (NUM_KEYS < 1 || NUM_KEYS > 8) begin : g_bad_num_keys
        $error("key_debounce: NUM_KEYS must be 1..8");
    end
    if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYC must be >= 2");
    end
    if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
        $error("key_debounce: LONG_CYC must exceed DEBOUNCE_CYC");
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC)
        ) u_ch (
            .clk_50m   (clk_50m),
            .rst_n     (rst_n),
            .key_n_i   (key_n_in[g]),
            .level_o   (key_level[g]),
            .press_o   (key_press[g]),
            .release_o (key_release[g]),
            .long_o    (key_long[g])
        );
    end

endmodule
